// File: rtl/lcd_message_scheduler.sv
// rtl/lcd_message_scheduler.sv - priority scheduler for the two-line text LCD
//
// Purpose: grants the LCD to one of NREQ message requesters (bit 0 highest
// priority), holds the granted texts and cursor on the driver inputs for
// HOLD_TICKS tick strobes, then serves the next request. With no eligible
// request the default (idle) screen is shown. A requester is served once per
// assertion of its req; it must drop req before it is eligible again.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              one-cycle timebase strobe (nominally 100 Hz)
//   req               level request per requester
//   req_line1/2       128-bit line texts per requester, first char in MSB byte
//   req_cursor        7-bit DDRAM cursor address per requester
//   default_line1/2   idle-screen texts
//   default_cursor    idle-screen cursor address
//   line1_text/2      registered texts to the LCD driver
//   ddram_address     registered cursor address to the LCD driver
//   refresh           one-cycle redraw strobe when presented content changes
//   grant             one-hot owner of the displayed message
//   done              one-cycle pulse when the owner's hold time expires
//   busy              high while loading or holding a message
//
// Build option: define LCD_MSG_PREEMPT_EN to let a higher-priority eligible
// requester interrupt a message in HOLD (restarting with a full hold time).

module lcd_message_scheduler #(
  parameter int NREQ       = 4,
  parameter int HOLD_TICKS = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*128-1:0]  req_line1,
  input  logic [NREQ*128-1:0]  req_line2,
  input  logic [NREQ*7-1:0]    req_cursor,
  input  logic [127:0]         default_line1,
  input  logic [127:0]         default_line2,
  input  logic [6:0]           default_cursor,
  output logic [127:0]         line1_text,
  output logic [127:0]         line2_text,
  output logic [6:0]           ddram_address,
  output logic                 refresh,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy
);

  localparam int          SELW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
  localparam logic [127:0] BLANK    = {16{8'h20}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0]   served_q, served_d;
  logic [127:0]      line1_q, line1_d;
  logic [127:0]      line2_q, line2_d;
  logic [6:0]        addr_q, addr_d;
  logic              refresh_q, refresh_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   eligible;
  logic              first_valid;
  logic [SELW-1:0]   first_sel;
  logic              load_default;

  always_comb begin
    eligible    = req & ~served_q;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    first_valid = 1'b0;
    first_sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        first_valid = 1'b1;
        first_sel   = SELW'(i);
      end
    end

    state_d      = state_q;
    sel_d        = sel_q;
    hold_cnt_d   = hold_cnt_q;
    // Dropping req re-arms the requester for a later serve.
    served_d     = served_q & req;
    line1_d      = line1_q;
    line2_d      = line2_q;
    addr_d       = addr_q;
    refresh_d    = 1'b0;
    grant_d      = grant_q;
    done_d       = '0;
    load_default = 1'b0;

    case (state_q)
      S_IDLE: begin
        load_default = 1'b1;
        if (first_valid) begin
          sel_d   = first_sel;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        line1_d          = req_line1[128*sel_q +: 128];
        line2_d          = req_line2[128*sel_q +: 128];
        addr_d           = req_cursor[7*sel_q +: 7];
        grant_d          = '0;
        grant_d[sel_q]   = 1'b1;
        refresh_d        = 1'b1;
        hold_cnt_d       = '0;
        state_d          = S_HOLD;
      end
      S_HOLD: begin
        // Abort outranks both preemption and expiry.
        if (!req[sel_q]) begin
          grant_d      = '0;
          load_default = 1'b1;
          state_d      = S_IDLE;
        end
`ifdef LCD_MSG_PREEMPT_EN
        else if (first_valid && (first_sel < sel_q)) begin
          sel_d   = first_sel;
          state_d = S_LOAD;
        end
`endif
        else if (tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            done_d[sel_q]   = 1'b1;
            served_d[sel_q] = 1'b1;
            grant_d         = '0;
            state_d         = S_DONE;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
      end
      S_DONE: begin
        // Default screen is restored on the edge leaving DONE.
        load_default = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_default) begin
      line1_d   = default_line1;
      line2_d   = default_line2;
      addr_d    = default_cursor;
      refresh_d = (default_line1 != line1_q) || (default_line2 != line2_q) ||
                  (default_cursor != addr_q);
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      hold_cnt_q <= '0;
      served_q   <= '0;
      line1_q    <= BLANK;
      line2_q    <= BLANK;
      addr_q     <= '0;
      refresh_q  <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hold_cnt_q <= hold_cnt_d;
      served_q   <= served_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
      addr_q     <= addr_d;
      refresh_q  <= refresh_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign line1_text    = line1_q;
  assign line2_text    = line2_q;
  assign ddram_address = addr_q;
  assign refresh       = refresh_q;
  assign grant         = grant_q;
  assign done          = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_lcd_message_scheduler.sv
// tb/tb_lcd_message_scheduler.sv - self-checking bench for lcd_message_scheduler

module tb_lcd_message_scheduler;

  localparam int NREQ = 4;
  localparam int HT   = 3;

  localparam logic [127:0] BLANK = {16{8'h20}};
  localparam logic [127:0] DEF1  = {"READY", {11{8'h20}}};
  localparam logic [127:0] DEF2  = {16{8'h2D}};
  localparam logic [6:0]   DEFC  = 7'h05;

  logic                clk;
  logic                rst;
  logic                tick;
  logic [NREQ-1:0]     req;
  logic [NREQ*128-1:0] req_line1;
  logic [NREQ*128-1:0] req_line2;
  logic [NREQ*7-1:0]   req_cursor;
  logic [127:0]        default_line1;
  logic [127:0]        default_line2;
  logic [6:0]          default_cursor;
  logic [127:0]        line1_text;
  logic [127:0]        line2_text;
  logic [6:0]          ddram_address;
  logic                refresh;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                busy;

  lcd_message_scheduler #(.NREQ(NREQ), .HOLD_TICKS(HT)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .req           (req),
    .req_line1     (req_line1),
    .req_line2     (req_line2),
    .req_cursor    (req_cursor),
    .default_line1 (default_line1),
    .default_line2 (default_line2),
    .default_cursor(default_cursor),
    .line1_text    (line1_text),
    .line2_text    (line2_text),
    .ddram_address (ddram_address),
    .refresh       (refresh),
    .grant         (grant),
    .done          (done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] msg1(input int i);
    logic [7:0] c;
    c = 8'h41 + 8'(i);
    return {16{c}};
  endfunction

  function automatic logic [127:0] msg2(input int i);
    logic [7:0] c;
    c = 8'h61 + 8'(i);
    return {16{c}};
  endfunction

  function automatic logic [6:0] curs(input int i);
    return 7'h40 + 7'(i);
  endfunction

  typedef struct {
    logic [3:0]   req;
    logic         tick;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic         refresh;
    logic [127:0] l1;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    logic [3:0] order0, order1;
    logic seen3;
    int ticks;

    // Single request (HOLD_TICKS=3), re-serve after req toggle, then abort.
    tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, DEF1};
    tbl[1]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, msg1(2)};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, msg1(2)};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, msg1(2)};
    tbl[4]  = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, msg1(2)};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b0, msg1(2)};
    tbl[6]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, DEF1};
    tbl[7]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, DEF1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, DEF1};
    tbl[9]  = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, DEF1};
    tbl[10] = '{4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, msg1(2)};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, DEF1};

    for (int i = 0; i < NREQ; i++) begin
      req_line1[128*i +: 128] = msg1(i);
      req_line2[128*i +: 128] = msg2(i);
      req_cursor[7*i +: 7]    = curs(i);
    end
    default_line1  = DEF1;
    default_line2  = DEF2;
    default_cursor = DEFC;
    req  = '0;
    tick = 1'b0;
    rst  = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_line1", line1_text, BLANK);
    chk("rst_line2", line2_text, BLANK);
    chk("rst_addr", 128'(ddram_address), 128'(7'h00));
    chk("rst_grant", 128'(grant), 128'(4'b0000));
    chk("rst_done", 128'(done), 128'(4'b0000));
    chk("rst_refresh", 128'(refresh), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));

    rst = 1'b0;
    step();
    chk("idle_line1", line1_text, DEF1);
    chk("idle_line2", line2_text, DEF2);
    chk("idle_addr", 128'(ddram_address), 128'(DEFC));
    chk("idle_refresh_on", 128'(refresh), 128'(1'b1));
    step();
    chk("idle_refresh_off", 128'(refresh), 128'(1'b0));

    // Table-driven single-request sequence.
    for (int i = 0; i < 12; i++) begin
      req  = tbl[i].req;
      tick = tbl[i].tick;
      step();
      chk($sformatf("tbl%0d_grant", i), 128'(grant), 128'(tbl[i].grant));
      chk($sformatf("tbl%0d_done", i), 128'(done), 128'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].busy));
      chk($sformatf("tbl%0d_refresh", i), 128'(refresh), 128'(tbl[i].refresh));
      chk($sformatf("tbl%0d_line1", i), line1_text, tbl[i].l1);
    end
    tick = 1'b0;
    step();

    // Priority and serve-once with req=1010 held.
    req    = 4'b1010;
    tick   = 1'b1;
    n_done = 0;
    order0 = '0;
    order1 = '0;
    seen3  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (done != 4'b0000) begin
        if (n_done == 0) order0 = done;
        if (n_done == 1) order1 = done;
        n_done++;
      end
      if (grant == 4'b1000 && !seen3) begin
        seen3 = 1'b1;
        chk("prio_line2_req3", line2_text, msg2(3));
        chk("prio_addr_req3", 128'(ddram_address), 128'(curs(3)));
      end
    end
    chk("prio_done_count", 128'(n_done), 128'(2));
    chk("prio_first", 128'(order0), 128'(4'b0010));
    chk("prio_second", 128'(order1), 128'(4'b1000));

    // Toggle req[1] low for one cycle: only requester 1 is served again.
    req = 4'b1000;
    step();
    req    = 4'b1010;
    n_done = 0;
    order0 = '0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done != 4'b0000) begin
        if (n_done == 0) order0 = done;
        n_done++;
      end
    end
    chk("reserve_count", 128'(n_done), 128'(1));
    chk("reserve_which", 128'(order0), 128'(4'b0010));
    req  = '0;
    tick = 1'b0;
    step();
    step();

    // Freeze: req_line2 changes during HOLD are not shown.
    req = 4'b0001;
    step();
    step();
    chk("frz_grant", 128'(grant), 128'(4'b0001));
    chk("frz_line2_load", line2_text, msg2(0));
    req_line2[127:0] = {4{32'hDEADBEEF}};
    tick = 1'b1;
    step();
    chk("frz_line2_t1", line2_text, msg2(0));
    step();
    chk("frz_line2_t2", line2_text, msg2(0));
    step();
    chk("frz_line2_t3", line2_text, msg2(0));
    chk("frz_done", 128'(done), 128'(4'b0001));
    req_line2[127:0] = msg2(0);
    req  = '0;
    tick = 1'b0;
    step();
    chk("frz_done_one_cycle", 128'(done), 128'(4'b0000));
    chk("frz_default_back", line2_text, DEF2);
    chk("frz_refresh", 128'(refresh), 128'(1'b1));
    step();

    // Abort after one tick of HOLD.
    req = 4'b0001;
    step();
    step();
    chk("abort_grant", 128'(grant), 128'(4'b0001));
    tick = 1'b1;
    step();
    tick = 1'b0;
    req  = 4'b0000;
    step();
    chk("abort_grant0", 128'(grant), 128'(4'b0000));
    chk("abort_done", 128'(done), 128'(4'b0000));
    chk("abort_busy", 128'(busy), 128'(1'b0));
    chk("abort_refresh", 128'(refresh), 128'(1'b1));
    chk("abort_line1", line1_text, DEF1);
    step();
    chk("abort_done_later", 128'(done), 128'(4'b0000));
    chk("abort_refresh_off", 128'(refresh), 128'(1'b0));

    // Reset asserted mid-HOLD.
    req = 4'b0100;
    step();
    step();
    chk("midrst_grant", 128'(grant), 128'(4'b0100));
    rst = 1'b1;
    step();
    chk("midrst_line1", line1_text, BLANK);
    chk("midrst_grant0", 128'(grant), 128'(4'b0000));
    chk("midrst_done", 128'(done), 128'(4'b0000));
    chk("midrst_busy", 128'(busy), 128'(1'b0));
    rst = 1'b0;
    req = '0;
    step();
    chk("midrst_default", line1_text, DEF1);
    step();

`ifdef LCD_MSG_PREEMPT_EN
    // Preemption: req[0] interrupts req[3].
    req = 4'b1000;
    step();
    step();
    chk("pre_grant3", 128'(grant), 128'(4'b1000));
    tick = 1'b1;
    step();
    tick = 1'b0;
    req  = 4'b1001;
    step();
    chk("pre_nodone_a", 128'(done), 128'(4'b0000));
    step();
    chk("pre_grant0", 128'(grant), 128'(4'b0001));
    chk("pre_nodone_b", 128'(done), 128'(4'b0000));
    chk("pre_line1", line1_text, msg1(0));
    tick = 1'b1;
    step();
    step();
    step();
    chk("pre_done0", 128'(done), 128'(4'b0001));
    tick = 1'b0;
    step();
    step();
    step();
    chk("pre_regrant3", 128'(grant), 128'(4'b1000));
    ticks = 0;
    tick  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (done == 4'b0000) begin
        step();
        ticks++;
      end
    end
    chk("pre_full_hold", 128'(ticks), 128'(HT));
    chk("pre_done3", 128'(done), 128'(4'b1000));
    tick = 1'b0;
    req  = '0;
    step();
    step();
`else
    // Without preemption req[0] waits for req[3] to finish.
    req = 4'b1000;
    step();
    step();
    chk("nopre_grant3", 128'(grant), 128'(4'b1000));
    tick = 1'b1;
    step();
    tick = 1'b0;
    req  = 4'b1001;
    step();
    step();
    chk("nopre_still3", 128'(grant), 128'(4'b1000));
    tick = 1'b1;
    step();
    step();
    chk("nopre_done3", 128'(done), 128'(4'b1000));
    tick = 1'b0;
    step();
    step();
    step();
    chk("nopre_then0", 128'(grant), 128'(4'b0001));
    req = '0;
    step();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_message_scheduler.md
# lcd_message_scheduler

Arbitrates access to the two-line 16-character text LCD between up to NREQ message requesters (menu, coin, dispense, error, ...) in the vending machine. The granted requester's line texts and cursor address are held on the display-driver inputs for a fixed number of ticks, then the next request is served. With no active request, the default (idle) screen is shown. A one-cycle refresh strobe tells the LCD driver to redraw whenever the presented content changes.

## Interface
- NREQ, 4: number of requesters; bit 0 has the highest priority.
- HOLD_TICKS, 200: message display time in `tick` strobes; legal range 1..65535.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle timebase strobe, nominally 100 Hz.
- req  in  NREQ  level request per requester.
- req_line1  in  NREQ*128  line-1 text per requester; requester i uses bits [128*i+127:128*i], first character in the MSB byte.
- req_line2  in  NREQ*128  line-2 text per requester; same packing as req_line1.
- req_cursor  in  NREQ*7  DDRAM cursor address per requester.
- default_line1, default_line2  in  128  idle-screen text.
- default_cursor  in  7  idle-screen cursor address.
- line1_text, line2_text  out  128  text to the LCD driver (registered).
- ddram_address  out  7  cursor address to the LCD driver (registered).
- refresh  out  1  one-cycle redraw strobe.
- grant  out  NREQ  one-hot; identifies the requester whose message is currently shown.
- done  out  NREQ  one-cycle pulse when that requester's hold time expires.
- busy  out  1  high in LOAD and HOLD.

## Operation
- Eligibility: eligible = req & ~served.
  - served[i] sets when done[i] pulses.
  - served[i] clears in any cycle where req[i]=0.
  - A requester must drop req before it can be served again.
- States:
  - IDLE: outputs load the default_* inputs every cycle. If eligible≠0, latch the lowest set index into sel and go to LOAD.
  - LOAD: outputs load the sel slices of req_line1, req_line2 and req_cursor. grant=onehot(sel), refresh=1, hold_cnt=0, go to HOLD.
  - HOLD: outputs are frozen, even if the requester changes its texts. Each tick increments hold_cnt. When tick is high and hold_cnt==HOLD_TICKS-1, go to DONE.
  - DONE: done[sel]=1 for one cycle, served[sel] set, grant=0, go to IDLE.
- Abort: if req[sel] falls in HOLD, go to IDLE next cycle. No done pulse; served is not set.
- refresh also pulses in IDLE in any cycle where the newly loaded default values differ from the previous output values. This covers the return from DONE or abort and live changes to the default text.
- Simultaneous events in HOLD: expiry and abort in the same cycle resolve as abort.
- Reset values:
  - state IDLE, sel 0, hold_cnt 0, served 0.
  - grant 0, done 0, refresh 0, busy 0.
  - line texts all 8'h20 (spaces), ddram_address 0.
- hold_cnt is 16 bits and never wraps, because it is compared against HOLD_TICKS-1.

## Timing
- Request to display: req sampled high at edge t in IDLE → LOAD after t → new outputs, grant and refresh valid after edge t+1. Latency is 2 cycles.
- Display interval: from LOAD to DONE spans exactly HOLD_TICKS tick strobes, counted from the first tick after LOAD.
- done is high 1 cycle. Default text is back on the outputs 1 cycle after DONE, with refresh high that cycle.
- tick arriving in the LOAD cycle is not counted.
- rst asserted mid-HOLD: on the next edge all outputs take their reset values; no done pulse.

## Configuration
- LCD_MSG_PREEMPT_EN defined:
  - In HOLD, if any eligible requester j has j < sel, go to LOAD with sel=j. The message restarts with a full hold time.
  - The preempted requester gets no done pulse, is not marked served, and is re-served from the start later.
- Undefined: HOLD is never interrupted except by abort or rst.

## Test plan
- Reset/idle: rst high 2 cycles → line1_text all 8'h20 and grant 0. Release rst with default_line1="READY" → outputs show "READY" 1 cycle later with refresh=1 for one cycle.
- Single request, HOLD_TICKS=3: req=4'b0100 → grant=4'b0100 two cycles later. done[2] pulses after the 3rd tick. Default text returns the next cycle with refresh=1.
- Priority/serve-once: req=4'b1010 held → req 1 served first, then req 3. Neither is served again until its req toggles low.
- Abort: req[0] drops after 1 tick of HOLD → IDLE next cycle, done stays 0, default shown with refresh=1.
- Freeze: requester changes req_line2 during HOLD → line2_text unchanged until DONE.
- Preemption, LCD_MSG_PREEMPT_EN defined: req[3] in HOLD, req[0] rises → grant=4'b0001 two cycles later, no done[3] pulse. req[3] is redisplayed for a full 3 ticks after done[0].
